// File: rtl/go_get_put_checker.sv
// Synthesizable checker for "go, then get on the next two cycles, implies two puts unless stop".
// Emits registered pass/fail/drop/timeout pulses, obligation status and saturating verdict counters.
module go_get_put_checker #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             get,
  input  logic             put,
  input  logic             stop,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic             drop,
  output logic             timeout,
  output logic [1:0]       puts_seen,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt
);

  localparam int              WW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WW-1:0]   WAIT_LAST = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic {S_IDLE = 1'b0, S_OPEN = 1'b1} state_t;

  state_t        r_state, w_state_next;
  logic          r_pc, w_pc_next;
  logic [WW-1:0] r_wait, w_wait_next, w_wait_inc;
  logic          w_to_hit;

  logic r_go, r_goget;
  logic w_match;
  logic w_pass, w_fail, w_drop, w_timeout;
  logic r_pass_p, r_fail_p, r_drop_p, r_timeout_p;

  assign w_match    = r_goget & get;
  assign w_wait_inc = (r_wait == {WW{1'b1}}) ? r_wait : r_wait + WW'(1);
  // r_wait holds the obligation cycles already completed; the current one makes it +1
  assign w_to_hit   = (TIMEOUT > 0) && (r_wait >= WAIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_go    <= 1'b0;
      r_goget <= 1'b0;
    end else begin
      r_go    <= go;
      r_goget <= r_go & get;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= 1'b0;
      r_wait  <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_wait  <= w_wait_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_wait_next  = r_wait;
    case (r_state)
      S_IDLE: begin
        if (w_match && !stop) begin
          w_state_next = S_OPEN;
          w_pc_next    = put;
          w_wait_next  = WW'(1);
        end
      end
      S_OPEN: begin
        if (stop || (put && r_pc) || (!put && w_to_hit)) begin
          w_state_next = S_IDLE;
          w_pc_next    = 1'b0;
          w_wait_next  = '0;
        end else begin
          if (put) w_pc_next = 1'b1;
          w_wait_next = w_wait_inc;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_pc_next    = 1'b0;
        w_wait_next  = '0;
      end
    endcase
  end

  always_comb begin
    w_pass    = 1'b0;
    w_fail    = 1'b0;
    w_drop    = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: w_fail = w_match & stop;
      S_OPEN: begin
        w_drop = w_match;
        if (stop)                w_fail    = 1'b1;
        else if (put && r_pc)    w_pass    = 1'b1;
        else if (!put && w_to_hit) w_timeout = 1'b1;
      end
      default: ;
    endcase
  end

  // Verdicts are staged once so they line up with busy/puts_seen one edge later
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pass_p    <= 1'b0;
      r_fail_p    <= 1'b0;
      r_drop_p    <= 1'b0;
      r_timeout_p <= 1'b0;
    end else begin
      r_pass_p    <= w_pass;
      r_fail_p    <= w_fail;
      r_drop_p    <= w_drop;
      r_timeout_p <= w_timeout;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      puts_seen <= 2'd0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      drop      <= 1'b0;
      timeout   <= 1'b0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
    end else begin
      busy      <= (r_state == S_OPEN);
      puts_seen <= {1'b0, r_pc};
      pass      <= r_pass_p;
      fail      <= r_fail_p;
      drop      <= r_drop_p;
      timeout   <= r_timeout_p;
      if (r_pass_p && pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + 1'b1;
      if (r_fail_p && fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_go_get_put_checker.sv
// Table-driven bench for go_get_put_checker: each row is one sample edge with its expected effect;
// expectations are queued at drive time and compared once the registered outputs show them.
module tb_go_get_put_checker;

  localparam int CNT_W   = 2;
  localparam int TIMEOUT = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             clk = 1'b0;
  logic             rst, go, get, put, stop;
  logic             busy, pass, fail, drop, timeout;
  logic [1:0]       puts_seen;
  logic [CNT_W-1:0] pass_cnt, fail_cnt;

  go_get_put_checker #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .go(go), .get(get), .put(put), .stop(stop),
    .busy(busy), .pass(pass), .fail(fail), .drop(drop), .timeout(timeout),
    .puts_seen(puts_seen), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  // in = {go,get,put,stop}; verd = {pass,fail,drop,timeout}
  typedef struct {
    logic       rst;
    logic [3:0] in;
    logic       busy;
    logic [1:0] ps;
    logic [3:0] verd;
  } vec_t;

  typedef struct {
    int               row;
    logic             busy;
    logic [1:0]       ps;
    logic [3:0]       verd;
    logic [CNT_W-1:0] pcnt;
    logic [CNT_W-1:0] fcnt;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic [CNT_W-1:0] m_pcnt, m_fcnt;

  function automatic vec_t mk(input logic r, input logic [3:0] in, input logic b,
                              input logic [1:0] ps, input logic [3:0] verd);
    vec_t v;
    v.rst = r; v.in = in; v.busy = b; v.ps = ps; v.verd = verd;
    return v;
  endfunction

  task automatic add(input logic [3:0] in, input logic b, input logic [1:0] ps, input logic [3:0] verd);
    vecs.push_back(mk(1'b0, in, b, ps, verd));
  endtask

  task automatic chk(input string name, input int row, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  task automatic compare_front();
    exp_t e;
    e = sb.pop_front();
    $display("row %0d: busy=%0b puts_seen=%0d pass=%0b fail=%0b drop=%0b timeout=%0b pass_cnt=%0d fail_cnt=%0d",
             e.row, busy, puts_seen, pass, fail, drop, timeout, pass_cnt, fail_cnt);
    chk("busy",      e.row, 8'(busy),      8'(e.busy));
    chk("puts_seen", e.row, 8'(puts_seen), 8'(e.ps));
    chk("pass",      e.row, 8'(pass),      8'(e.verd[3]));
    chk("fail",      e.row, 8'(fail),      8'(e.verd[2]));
    chk("drop",      e.row, 8'(drop),      8'(e.verd[1]));
    chk("timeout",   e.row, 8'(timeout),   8'(e.verd[0]));
    chk("pass_cnt",  e.row, 8'(pass_cnt),  8'(e.pcnt));
    chk("fail_cnt",  e.row, 8'(fail_cnt),  8'(e.fcnt));
  endtask

  task automatic apply(input vec_t v, input int row);
    exp_t e;
    exp_t t;
    @(negedge clk);
    if (sb.size() == 2) compare_front();
    rst = v.rst;
    {go, get, put, stop} = v.in;
    if (v.rst) begin
      // Reset at this edge also wipes what the previous row would have shown after it
      m_pcnt = '0;
      m_fcnt = '0;
      if (sb.size() > 0) begin
        t = sb.pop_back();
        t.busy = 1'b0; t.ps = 2'd0; t.verd = 4'd0; t.pcnt = '0; t.fcnt = '0;
        sb.push_back(t);
      end
    end else begin
      if (v.verd[3] && m_pcnt != CNT_MAX) m_pcnt = m_pcnt + 1'b1;
      if (v.verd[2] && m_fcnt != CNT_MAX) m_fcnt = m_fcnt + 1'b1;
    end
    e.row  = row;
    e.busy = v.rst ? 1'b0 : v.busy;
    e.ps   = v.rst ? 2'd0 : v.ps;
    e.verd = v.rst ? 4'd0 : v.verd;
    e.pcnt = m_pcnt;
    e.fcnt = m_fcnt;
    sb.push_back(e);
  endtask

  initial begin
    rst = 1'b1; go = 1'b0; get = 1'b0; put = 1'b0; stop = 1'b0;
    m_pcnt = '0; m_fcnt = '0;

    // reset state
    vecs.push_back(mk(1'b1, 4'b0000, 1'b0, 2'd0, 4'b0000));
    vecs.push_back(mk(1'b1, 4'b1110, 1'b0, 2'd0, 4'b0000));
    add(4'b0000, 0, 0, 4'b0000);
    add(4'b0000, 0, 0, 4'b0000);
    // basic pass: put@2,5
    add(4'b1000, 0, 0, 4'b0000);
    add(4'b0100, 0, 0, 4'b0000);
    add(4'b0110, 1, 1, 4'b0000);
    add(4'b0000, 1, 1, 4'b0000);
    add(4'b0000, 1, 1, 4'b0000);
    add(4'b0010, 0, 0, 4'b1000);
    add(4'b0000, 0, 0, 4'b0000);
    // stop abort: put@3, stop@4
    add(4'b1000, 0, 0, 4'b0000);
    add(4'b0100, 0, 0, 4'b0000);
    add(4'b0100, 1, 0, 4'b0000);
    add(4'b0010, 1, 1, 4'b0000);
    add(4'b0001, 0, 0, 4'b0100);
    add(4'b0000, 0, 0, 4'b0000);
    // stop wins over simultaneous second put
    add(4'b1000, 0, 0, 4'b0000);
    add(4'b0100, 0, 0, 4'b0000);
    add(4'b0110, 1, 1, 4'b0000);
    add(4'b0000, 1, 1, 4'b0000);
    add(4'b0011, 0, 0, 4'b0100);
    add(4'b0000, 0, 0, 4'b0000);
    // antecedent miss: get low at 2
    add(4'b1000, 0, 0, 4'b0000);
    add(4'b0100, 0, 0, 4'b0000);
    add(4'b0000, 0, 0, 4'b0000);
    add(4'b0010, 0, 0, 4'b0000);
    add(4'b0000, 0, 0, 4'b0000);
    // overlap: match at 2 opens, match at 3 dropped, then timeout after four cycles
    add(4'b1000, 0, 0, 4'b0000);
    add(4'b1100, 0, 0, 4'b0000);
    add(4'b0100, 1, 0, 4'b0000);
    add(4'b0100, 1, 0, 4'b0010);
    add(4'b0000, 1, 0, 4'b0000);
    add(4'b0000, 0, 0, 4'b0001);
    add(4'b0000, 0, 0, 4'b0000);
    // drop coinciding with pass: second match lands on the resolving cycle
    add(4'b1000, 0, 0, 4'b0000);
    add(4'b0100, 0, 0, 4'b0000);
    add(4'b0110, 1, 1, 4'b0000);
    add(4'b1000, 1, 1, 4'b0000);
    add(4'b0100, 1, 1, 4'b0000);
    add(4'b0110, 0, 0, 4'b1010);
    add(4'b0000, 0, 0, 4'b0000);
    // stop on the match cycle itself
    add(4'b1000, 0, 0, 4'b0000);
    add(4'b0100, 0, 0, 4'b0000);
    add(4'b0101, 0, 0, 4'b0100);
    add(4'b0000, 0, 0, 4'b0000);
    // reset mid-obligation with one put counted
    add(4'b1000, 0, 0, 4'b0000);
    add(4'b0100, 0, 0, 4'b0000);
    add(4'b0110, 1, 1, 4'b0000);
    vecs.push_back(mk(1'b1, 4'b0010, 1'b0, 2'd0, 4'b0000));
    add(4'b0000, 0, 0, 4'b0000);
    add(4'b0000, 0, 0, 4'b0000);
    // five minimum-latency passes saturate the 2-bit counter
    for (int n = 0; n < 5; n++) begin
      add(4'b1000, 0, 0, 4'b0000);
      add(4'b0100, 0, 0, 4'b0000);
      add(4'b0110, 1, 1, 4'b0000);
      add(4'b0010, 0, 0, 4'b1000);
      add(4'b0000, 0, 0, 4'b0000);
    end
    add(4'b0000, 0, 0, 4'b0000);

    foreach (vecs[i]) apply(vecs[i], i);
    {go, get, put, stop} = 4'b0000;
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (sb.size() > 0) compare_front();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/go_get_put_checker.md
# go_get_put_checker

Synthesizable hardware checker that consumes the `go`/`get`/`put`/`stop` handshake and evaluates, cycle by cycle, the rule "`go`, then `get` on the next two cycles, implies two `put`s unless `stop` intervenes". It sits directly downstream of the handshake producer, alongside the simulation assertion on the same signals. It gives FPGA/emulation builds the same pass/fail verdicts, plus counters and a timeout.

## Interface
- `CNT_W`, default 16: width of the saturating verdict counters.
- `TIMEOUT`, default 64: maximum obligation length in cycles. 0 disables the timeout.
- `clk  in  1`: single clock; every input is sampled on the rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `go  in  1`: request start.
- `get  in  1`: get beat.
- `put  in  1`: put beat.
- `stop  in  1`: abort; rejects any open obligation.
- `busy  out  1`: an obligation is open.
- `pass  out  1`: one-cycle pulse; an obligation completed.
- `fail  out  1`: one-cycle pulse; an obligation was rejected by `stop`.
- `drop  out  1`: one-cycle pulse; an antecedent match was ignored because an obligation was already open.
- `timeout  out  1`: one-cycle pulse; an obligation was abandoned after `TIMEOUT` cycles. This is not a failure.
- `puts_seen  out  2`: number of `put`s counted in the current obligation (0 or 1).
- `pass_cnt  out  CNT_W`: saturating count of `pass` events.
- `fail_cnt  out  CNT_W`: saturating count of `fail` events.

## Operation
- **Antecedent recognizer.** Runs continuously, independent of the obligation state.
  - `r_go` is set to `go` each cycle.
  - `r_goget` is set to `r_go & get` each cycle.
  - A match occurs in sample cycle M when `r_goget & get` holds.
  - Overlapping matches are detected: `go` high on consecutive cycles with `get` held high produces a match in each cycle.
- **Obligation state machine**, states IDLE and OPEN, with a put counter `pc` (0..1).
- **IDLE, match in cycle M.** The obligation starts in cycle M itself (overlapping implication). Cycle M is evaluated as the first obligation cycle:
  - `stop` → `fail`, stay IDLE.
  - else `put` and `pc` would reach 2 → not possible on the first cycle. Instead, `put` sets `pc=1` and the state goes to OPEN.
  - else → OPEN with `pc=0`.
- **OPEN, each cycle, in this priority order:**
  1. `stop` → `fail`, go to IDLE. `stop` wins over a simultaneous second `put`.
  2. `put` with `pc==1` → `pass`, go to IDLE.
  3. `put` with `pc==0` → `pc=1`.
  4. wait counter reaches `TIMEOUT` → `timeout`, go to IDLE.
- **Match while OPEN** (state at the start of the cycle): `drop` pulses and the match is not queued. This holds even if the open obligation resolves in the same cycle.
- **Wait counter.** Width is `$clog2(TIMEOUT+1)`. It counts obligation cycles including cycle M and clears on entry to IDLE.
- **Counters.** `pass_cnt` and `fail_cnt` increment on their verdicts and saturate at `2**CNT_W-1`. `timeout` and `drop` are not counted.
- **Reset.** All state, pulses and counters go to 0. The state goes to IDLE. `r_go` and `r_goget` clear, so no match is possible in the first two cycles after reset.

## Timing
- All outputs are registered.
- A verdict for sample edge k is visible for exactly one cycle, from edge k+1.
- `busy` and `puts_seen` reflect the state after edge k+1.
- Minimum `pass` latency: `go` at edge t, `get` at t+1 and t+2, `put` at t+2 and t+3 → `pass` high after edge t+4.
- Pulse exclusivity: `pass`, `fail` and `timeout` are mutually exclusive. `drop` may coincide with any of them.
- `rst` asserted mid-obligation: the obligation is discarded with no verdict, and outputs are 0 after that edge.

## Test plan
- **Basic pass.** `go`@0, `get`@1,2, `put`@2,5, `stop` low → `pass`=1 after edge 6, `pass_cnt`=1, `busy` high from edge 3 through edge 5.
- **Stop abort.** Same antecedent, `put`@3, `stop`@4 → `fail` after edge 5, `fail_cnt`=1, no `pass`.
- **Simultaneous stop and second put.** `put`@2, `put`+`stop`@4 → `fail` only.
- **Antecedent miss and overlap.**
  - `get` low at 2 → no obligation, `busy` stays 0.
  - `go`@0,1 with `get`@1,2,3 and no `put`s → match at 2 opens the obligation; match at 3 produces `drop` after edge 4.
- **Timeout.** `TIMEOUT`=4, antecedent match at 2, no `put` → `timeout` after edge 6, counters unchanged, `busy`=0.
- **Reset and saturation.**
  - `rst` at 3 with `pc`=1 → all outputs 0 after edge 4, no verdict.
  - With `CNT_W`=2, five passes → `pass_cnt`=3.
